// File: rtl/idex_issue_ctrl.sv
// Issue controller for the IDU->EXU pipeline register: RAW scoreboard, control-flow
// serialisation and fence.i/CSR drain. Optional macro WB_BYPASS_EN enables same-cycle WB forwarding.
module idex_issue_ctrl #(
  parameter int unsigned NREG  = 32,
  parameter int unsigned CNT_W = 2
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       id_valid,
  input  logic [4:0] id_rs1,
  input  logic [4:0] id_rs2,
  input  logic       id_rs1_en,
  input  logic       id_rs2_en,
  input  logic [4:0] id_rd,
  input  logic       id_wen,
  input  logic       id_ctrl,
  input  logic       id_drain,
  input  logic       ex_ready,
  input  logic       wb_valid,
  input  logic [4:0] wb_rd,
  input  logic       wb_wen,
  input  logic       ctrl_resolved,
  input  logic       fencei_done,
  output logic       issue_valid,
  output logic       id_ready,
  output logic       fencei_req,
  output logic [2:0] inflight
);

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    DRAIN  = 2'd1,
    FENCE  = 2'd2,
    ISSUE1 = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  state_t           state, state_next;
  logic [CNT_W-1:0] cnt [NREG];
  logic [2:0]       inflight_q;
  logic             ctrl_pend;

  logic [CNT_W-1:0] rs1_cnt, rs2_cnt, rd_cnt;
  logic             wb_ret;
  logic             rs1_busy, rs2_busy;
  logic             rs1_bypass, rs2_bypass;
  logic             hazard, sat;
  logic             issue;
  logic             retire;
  logic [NREG-1:0]  inc_vec, dec_vec;

  always_comb begin
    rs1_cnt  = cnt[id_rs1];
    rs2_cnt  = cnt[id_rs2];
    rd_cnt   = cnt[id_rd];
    wb_ret   = wb_valid & wb_wen & (wb_rd != '0);
    rs1_busy = id_rs1_en & (id_rs1 != '0) & (rs1_cnt != '0);
    rs2_busy = id_rs2_en & (id_rs2 != '0) & (rs2_cnt != '0);
`ifdef WB_BYPASS_EN
    // last pending write to this source retires now; EXU picks the value off the WB bus
    rs1_bypass = wb_ret & (wb_rd == id_rs1) & (rs1_cnt == CNT_ONE);
    rs2_bypass = wb_ret & (wb_rd == id_rs2) & (rs2_cnt == CNT_ONE);
`else
    rs1_bypass = 1'b0;
    rs2_bypass = 1'b0;
`endif
    hazard = (rs1_busy & ~rs1_bypass) | (rs2_busy & ~rs2_bypass);
    sat    = (id_wen & (id_rd != '0) & (rd_cnt == CNT_MAX)) | (inflight_q == 3'd7);
  end

  always_comb begin
    state_next = state;
    issue      = 1'b0;
    case (state)
      RUN: begin
        issue = id_valid & ex_ready & ~hazard & ~sat & ~ctrl_pend & ~id_drain;
        if (id_valid & id_drain & ~ctrl_pend)
          state_next = DRAIN;
      end
      DRAIN: begin
        if (inflight_q == '0)
          state_next = (~id_ctrl & id_drain & ~id_wen) ? FENCE : ISSUE1;
      end
      FENCE: begin
        if (fencei_done)
          state_next = ISSUE1;
      end
      ISSUE1: begin
        issue = id_valid & ex_ready;
        if (issue)
          state_next = RUN;
      end
      default: state_next = RUN;
    endcase
  end

  assign issue_valid = issue;
  assign id_ready    = issue;
  assign fencei_req  = (state == FENCE);
  assign inflight    = inflight_q;
  assign retire      = wb_valid & (inflight_q != '0);

  always_comb begin
    inc_vec = '0;
    dec_vec = '0;
    for (int unsigned i = 1; i < NREG; i++) begin
      inc_vec[i] = issue & id_wen & (id_rd == 5'(i));
      dec_vec[i] = wb_ret & (wb_rd == 5'(i)) & (cnt[i] != '0);
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset)
      state <= RUN;
    else
      state <= state_next;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < NREG; i++)
        cnt[i] <= '0;
    end else begin
      for (int unsigned i = 0; i < NREG; i++) begin
        if (inc_vec[i] & ~dec_vec[i])
          cnt[i] <= cnt[i] + CNT_ONE;
        else if (dec_vec[i] & ~inc_vec[i])
          cnt[i] <= cnt[i] - CNT_ONE;
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      inflight_q <= '0;
    end else if (issue & ~retire) begin
      inflight_q <= inflight_q + 3'd1;
    end else if (retire & ~issue) begin
      inflight_q <= inflight_q - 3'd1;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset)
      ctrl_pend <= 1'b0;
    else if (issue & id_ctrl)
      ctrl_pend <= 1'b1;
    else if (ctrl_resolved)
      ctrl_pend <= 1'b0;
  end

endmodule

// File: tb/tb_idex_issue_ctrl.sv
// Directed bench for idex_issue_ctrl: scoreboard stalls, control serialisation, fence.i drain,
// counter saturation and async reset. Expectations follow WB_BYPASS_EN when defined.
module tb_idex_issue_ctrl;

  logic       clock = 1'b0;
  logic       reset;
  logic       id_valid, id_rs1_en, id_rs2_en, id_wen, id_ctrl, id_drain, ex_ready;
  logic [4:0] id_rs1, id_rs2, id_rd, wb_rd;
  logic       wb_valid, wb_wen, ctrl_resolved, fencei_done;
  logic       issue_valid, id_ready, fencei_req;
  logic [2:0] inflight;

  int errors = 0;
  int checks = 0;

  always #5 clock = ~clock;

  idex_issue_ctrl #(.NREG(32), .CNT_W(2)) dut (
    .clock(clock), .reset(reset),
    .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_rs1_en(id_rs1_en), .id_rs2_en(id_rs2_en),
    .id_rd(id_rd), .id_wen(id_wen), .id_ctrl(id_ctrl), .id_drain(id_drain),
    .ex_ready(ex_ready), .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_wen(wb_wen),
    .ctrl_resolved(ctrl_resolved), .fencei_done(fencei_done),
    .issue_valid(issue_valid), .id_ready(id_ready), .fencei_req(fencei_req),
    .inflight(inflight)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic clr_id;
    id_valid = 0; id_rs1 = 0; id_rs2 = 0; id_rs1_en = 0; id_rs2_en = 0;
    id_rd = 0; id_wen = 0; id_ctrl = 0; id_drain = 0;
  endtask

  task automatic retire(input logic [4:0] rd, input logic wen);
    wb_valid = 1; wb_rd = rd; wb_wen = wen;
    tick;
    wb_valid = 0; wb_wen = 0; wb_rd = 0;
  endtask

  initial begin
    reset = 1; clr_id; ex_ready = 1;
    wb_valid = 0; wb_rd = 0; wb_wen = 0; ctrl_resolved = 0; fencei_done = 0;
    #1;
    check("rst_issue", issue_valid, 0);
    check("rst_fencei_req", fencei_req, 0);
    check("rst_inflight", inflight, 0);
    tick; tick;
    reset = 0;
    #1;

    // 1: zero-latency issue after reset
    id_valid = 1; id_rs1 = 1; id_rs1_en = 1; id_rd = 2; id_wen = 1;
    #1;
    check("t1_issue", issue_valid, 1);
    check("t1_ready", id_ready, 1);
    tick;
    check("t1_inflight", inflight, 1);
    id_rs1 = 2; id_rd = 0; id_wen = 0;
    #1;
    check("t1_cnt2_busy", issue_valid, 0);
    check("t1_ready_busy", id_ready, 0);

    // 2: RAW stall released by write-back
    id_rs1_en = 0; id_rd = 5; id_wen = 1;
    #1;
    check("t2_prod_issue", issue_valid, 1);
    tick;
    id_rs1 = 5; id_rs1_en = 1; id_rd = 7; id_wen = 1;
    #1;
    check("t2_raw_stall", issue_valid, 0);
    tick;
    check("t2_raw_stall2", issue_valid, 0);
    wb_valid = 1; wb_wen = 1; wb_rd = 5;
    #1;
`ifdef WB_BYPASS_EN
    check("t2_bypass_issue", issue_valid, 1);
`else
    check("t2_wb_cycle_stall", issue_valid, 0);
`endif
    tick;
    wb_valid = 0; wb_wen = 0; wb_rd = 0;
`ifndef WB_BYPASS_EN
    #1;
    check("t2_issue_after_wb", issue_valid, 1);
    tick;
`endif
    id_valid = 0;
    #1;
    check("t2_inflight", inflight, 2);
    retire(5'd2, 1'b1);
    retire(5'd7, 1'b1);
    check("t2_drained", inflight, 0);
    clr_id; id_valid = 1; id_rs1 = 7; id_rs1_en = 1;
    #1;
    check("t2_cnt7_clear", issue_valid, 1);

    // 3: x0 never tracked
    clr_id; id_valid = 1; id_rs1_en = 1; id_rs2_en = 1; id_rd = 0; id_wen = 1;
    #1;
    check("t3_x0_issue", issue_valid, 1);
    tick;
    check("t3_x0_issue2", issue_valid, 1);
    tick;
    id_valid = 0;
    #1;
    check("t3_inflight", inflight, 2);
    retire(5'd0, 1'b1);
    retire(5'd0, 1'b1);
    check("t3_inflight0", inflight, 0);

    // 4: control-flow serialisation
    clr_id; id_valid = 1; id_ctrl = 1; id_rd = 1; id_wen = 1;
    #1;
    check("t4_jal_issue", issue_valid, 1);
    tick;
    id_ctrl = 0; id_wen = 0; id_rd = 0;
    #1;
    check("t4_ctrl_block", issue_valid, 0);
    tick;
    check("t4_ctrl_block2", issue_valid, 0);
    ctrl_resolved = 1;
    #1;
    check("t4_pulse_cycle", issue_valid, 0);
    tick;
    ctrl_resolved = 0;
    #1;
    check("t4_after_pulse", issue_valid, 1);
    tick;
    id_valid = 0;
    #1;
    check("t4_inflight", inflight, 2);
    retire(5'd1, 1'b1);
    retire(5'd0, 1'b0);
    check("t4_inflight0", inflight, 0);

    // 5: fence.i drain / invalidate / single issue
    clr_id; id_valid = 1;
    #1;
    check("t5_pre_issue", issue_valid, 1);
    tick; tick;
    check("t5_inflight2", inflight, 2);
    id_drain = 1;
    #1;
    check("t5_drain_block", issue_valid, 0);
    tick;
    check("t5_drain_noreq", fencei_req, 0);
    check("t5_drain_noissue", issue_valid, 0);
    retire(5'd0, 1'b0);
    retire(5'd0, 1'b0);
    check("t5_inflight0", inflight, 0);
    check("t5_still_drain", fencei_req, 0);
    tick;
    check("t5_fence_req", fencei_req, 1);
    check("t5_fence_noissue", issue_valid, 0);
    tick;
    check("t5_fence_hold", fencei_req, 1);
    fencei_done = 1;
    #1;
    check("t5_done_cycle_req", fencei_req, 1);
    tick;
    fencei_done = 0; ex_ready = 0;
    #1;
    check("t5_issue1_req_off", fencei_req, 0);
    check("t5_issue1_exbusy", issue_valid, 0);
    ex_ready = 1;
    #1;
    check("t5_issue1_issue", issue_valid, 1);
    tick;
    id_drain = 0;
    #1;
    check("t5_back_in_run", issue_valid, 1);
    check("t5_inflight1", inflight, 1);
    id_valid = 0;
    retire(5'd0, 1'b0);

    // 6: per-register counter saturation
    clr_id; id_valid = 1; id_rd = 3; id_wen = 1;
    for (int k = 0; k < 3; k++) begin
      #1;
      check($sformatf("t6_write%0d", k), issue_valid, 1);
      tick;
    end
    check("t6_sat_block", issue_valid, 0);
    tick;
    check("t6_sat_block2", issue_valid, 0);
    wb_valid = 1; wb_wen = 1; wb_rd = 3;
    #1;
    check("t6_sat_wb_cycle", issue_valid, 0);
    tick;
    wb_valid = 0; wb_wen = 0; wb_rd = 0;
    #1;
    check("t6_sat_release", issue_valid, 1);
    tick;
    id_valid = 0;
    #1;
    check("t6_inflight3", inflight, 3);

    // asynchronous reset mid-operation, no clock edge involved
    reset = 1;
    #1;
    check("arst_inflight", inflight, 0);
    check("arst_fencei_req", fencei_req, 0);
    #1;
    reset = 0;
    clr_id; id_valid = 1; id_rs1 = 3; id_rs1_en = 1;
    #1;
    check("arst_cnt_cleared", issue_valid, 1);
    tick;
    clr_id;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: got 0 expected 1");
    $fatal(1);
  end

endmodule
